mmu_rx_rcmd_dispatch: RTL and testbench
=======================================

// Module: mmu_rx_rcmd_dispatch
// PURPOSE
//  Parametrised DDR read-command dispatcher for the MMU RX path. Takes one BD-derived read-command stream and issues
//  it as AXI4 AR beats on DDR_NUM (1..4) DDR channels. Replaces fixed per-channel wiring with address-hash or
//  round-robin channel selection.
//  Tracks outstanding bursts per channel with a credit cap and flags per-channel read-data timeouts for the CPU registers.
// PARAMETERS
//  DDR_NUM      4   number of DDR channels, 1..4
//  MAX_OUTS     8   max outstanding AR bursts per channel, 1..15
//  ID_WTH       4   AXI ID width
//  CHN_SEL_LSB  34  LSB of the araddr bits used for channel hash in mode 0
// PORTS
//  clk_sys            in   1               system clock
//  rst_n              in   1               asynchronous reset, active low
//  cmd_valid          in   1               read command valid
//  cmd_ready          out  1               read command accepted when valid&ready
//  cmd_addr           in   64              byte address
//  cmd_len            in   8               AXI arlen (beats-1)
//  cmd_id             in   ID_WTH          AXI arid
//  axi4m_ddr_arid     out  ID_WTH*DDR_NUM  per-channel arid
//  axi4m_ddr_araddr   out  64*DDR_NUM      per-channel araddr
//  axi4m_ddr_arlen    out  8*DDR_NUM       per-channel arlen
//  axi4m_ddr_arsize   out  3*DDR_NUM       per-channel arsize, constant 3'b110
//  axi4m_ddr_arvalid  out  DDR_NUM         per-channel arvalid
//  axi4m_ddr_arready  in   DDR_NUM         per-channel arready
//  rlast_done         in   DDR_NUM         pulse per channel on rvalid&rready&rlast
//  cfg_en             in   1               dispatch enable
//  cfg_mode           in   1               0 = address hash, 1 = round-robin
//  reg_timer_1us_cfg  in   8               clk_sys cycles per 1 us, minus 1
//  reg_tmout_us_cfg   in   16              timeout in us; 0 disables timeout
//  cnt_reg_clr        in   1               clears sticky errors
//  outs_cnt           out  4*DDR_NUM       per-channel outstanding burst count
//  tmout_err          out  DDR_NUM         sticky per-channel timeout
//  undf_err           out  DDR_NUM         sticky per-channel rlast_done received with outs_cnt==0
// BEHAVIOUR
//  Reset: all outputs 0, including cmd_ready. RR pointer = 0. All counters = 0.
//  Channel available:
//   - one-entry AR holding register per channel is empty, and
//   - outs_cnt < MAX_OUTS.
//  cmd_ready (combinational from registered state and cmd_addr):
//   - mode 0: ready = cfg_en & target available.
//     - Target = cmd_addr[CHN_SEL_LSB +: clog2(DDR_NUM)] mod DDR_NUM; DDR_NUM==1 -> target 0.
//     - DDR_NUM must be a power of 2 in this mode.
//   - mode 1: ready = cfg_en & any channel available.
//     - Target = first available channel scanning from rr_ptr upward with wrap.
//  Accept in cycle N: holding register loads, arvalid high in cycle N+1 (1-cycle latency). No bypass path.
//   - Mode 1: rr_ptr <= target+1, wrapping DDR_NUM-1 -> 0.
//   - A register is refilled no earlier than the cycle after its arvalid&arready.
//  AR handshake: arvalid and the AR fields stay stable until arready; arvalid drops the cycle after the handshake.
//  outs_cnt per channel:
//   - +1 on arvalid&arready; -1 on rlast_done; both in the same cycle -> unchanged.
//   - rlast_done at 0 -> stays 0 and sets undf_err.
//  cfg_en deasserted mid-stream stops new accepts only. Held AR beats still issue; outstanding bursts drain.
//  cfg_mode change takes effect on the next accept. A pending holding register is unaffected.
//  Timeout:
//   - Free-running tick counter pulses every reg_timer_1us_cfg+1 cycles.
//   - Per-channel 16-bit us counter: increments on tick while outs_cnt>0; clears on rlast_done or outs_cnt==0.
//   - When us counter == reg_tmout_us_cfg (non-zero), tmout_err is set. The counter saturates and does not wrap.
//  Sticky errors clear on cnt_reg_clr. A simultaneous set wins over the clear.
//  rst_n asserted mid-burst drops all state immediately. No AR is re-issued after reset.
// TESTING
//  1. Mode 0, DDR_NUM=4, addr bits[35:34]=2, len 7 -> only ch2 arvalid at N+1; outs_cnt[2]=1; rlast_done[2] -> 0.
//  2. Mode 1, 4 back-to-back cmds, arready=1 -> channel order 0,1,2,3; 5th cmd goes to ch0.
//     With ch1 stalled (arready=0), the next cmds skip ch1.
//  3. MAX_OUTS=8 on ch0, no rlast_done, mode 0 -> 8 ARs issued, then cmd_ready=0.
//     One rlast_done -> cmd_ready=1 next cycle.
//  4. Same-cycle AR handshake and rlast_done on ch3 at outs_cnt=5 -> stays 5.
//     rlast_done at outs_cnt=0 -> undf_err[3]=1, cleared by cnt_reg_clr.
//  5. reg_timer_1us_cfg=9, reg_tmout_us_cfg=3, ch1 outstanding with no rlast -> tmout_err[1]=1 after ~40 cycles.
//     reg_tmout_us_cfg=0 -> never set.
//  6. rst_n low while ch0 arvalid=1 and outs_cnt=4 -> all outputs 0 asynchronously.
//     After release, cmd_ready returns with cfg_en=1.

Source files
------------

// File: rtl/mmu_rx_rcmd_dispatch.sv
// MMU RX read-command dispatcher: spreads one read-command stream over DDR_NUM AXI4 AR channels
// by address hash or round-robin, with per-channel outstanding-burst credits and read-data timeouts.
module mmu_rx_rcmd_dispatch #(
  parameter int DDR_NUM     = 4,
  parameter int MAX_OUTS    = 8,
  parameter int ID_WTH      = 4,
  parameter int CHN_SEL_LSB = 34
) (
  input  logic                        clk_sys,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [63:0]                 cmd_addr,
  input  logic [7:0]                  cmd_len,
  input  logic [ID_WTH-1:0]           cmd_id,
  output logic [ID_WTH*DDR_NUM-1:0]   axi4m_ddr_arid,
  output logic [64*DDR_NUM-1:0]       axi4m_ddr_araddr,
  output logic [8*DDR_NUM-1:0]        axi4m_ddr_arlen,
  output logic [3*DDR_NUM-1:0]        axi4m_ddr_arsize,
  output logic [DDR_NUM-1:0]          axi4m_ddr_arvalid,
  input  logic [DDR_NUM-1:0]          axi4m_ddr_arready,
  input  logic [DDR_NUM-1:0]          rlast_done,
  input  logic                        cfg_en,
  input  logic                        cfg_mode,
  input  logic [7:0]                  reg_timer_1us_cfg,
  input  logic [15:0]                 reg_tmout_us_cfg,
  input  logic                        cnt_reg_clr,
  output logic [4*DDR_NUM-1:0]        outs_cnt,
  output logic [DDR_NUM-1:0]          tmout_err,
  output logic [DDR_NUM-1:0]          undf_err
);

  localparam int SEL_W = (DDR_NUM > 1) ? $clog2(DDR_NUM) : 1;

  logic                active_q;
  logic [DDR_NUM-1:0]  hold_vld;
  logic [63:0]         hold_addr [DDR_NUM];
  logic [7:0]          hold_len  [DDR_NUM];
  logic [ID_WTH-1:0]   hold_id   [DDR_NUM];
  logic [3:0]          cnt_q     [DDR_NUM];
  logic [15:0]         us_cnt    [DDR_NUM];
  logic [7:0]          tick_cnt;
  logic                tick;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    hash_tgt;
  logic [SEL_W-1:0]    rr_tgt;
  logic [SEL_W-1:0]    scan_idx;
  logic [SEL_W-1:0]    tgt;
  logic                rr_found;
  logic                accept;
  logic [DDR_NUM-1:0]  avail;
  logic [DDR_NUM-1:0]  ar_hs;

  // A channel can take a command only with an empty holding register and a free credit.
  always_comb begin
    avail = '0;
    for (int c = 0; c < DDR_NUM; c++) begin
      avail[c] = !hold_vld[c] && (cnt_q[c] < 4'(MAX_OUTS));
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_tgt   = '0;
    scan_idx = '0;
    for (int i = 0; i < DDR_NUM; i++) begin
      scan_idx = SEL_W'((int'(rr_ptr) + i) % DDR_NUM);
      if (!rr_found && avail[scan_idx]) begin
        rr_found = 1'b1;
        rr_tgt   = scan_idx;
      end
    end
  end

  assign hash_tgt  = (DDR_NUM == 1) ? '0 : SEL_W'(int'(cmd_addr[CHN_SEL_LSB +: SEL_W]) % DDR_NUM);
  assign tgt       = cfg_mode ? rr_tgt : hash_tgt;
  assign cmd_ready = active_q & cfg_en & (cfg_mode ? rr_found : avail[hash_tgt]);
  assign accept    = cmd_valid & cmd_ready;
  assign ar_hs     = hold_vld & axi4m_ddr_arready;
  assign tick      = (tick_cnt == reg_timer_1us_cfg);
  assign axi4m_ddr_arvalid = hold_vld;

  always_comb begin
    axi4m_ddr_arid   = '0;
    axi4m_ddr_araddr = '0;
    axi4m_ddr_arlen  = '0;
    axi4m_ddr_arsize = '0;
    outs_cnt         = '0;
    for (int c = 0; c < DDR_NUM; c++) begin
      axi4m_ddr_arid[c*ID_WTH +: ID_WTH] = hold_id[c];
      axi4m_ddr_araddr[c*64 +: 64]       = hold_addr[c];
      axi4m_ddr_arlen[c*8 +: 8]          = hold_len[c];
      axi4m_ddr_arsize[c*3 +: 3]         = active_q ? 3'b110 : 3'b000;
      outs_cnt[c*4 +: 4]                 = cnt_q[c];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      tick_cnt  <= '0;
      rr_ptr    <= '0;
      hold_vld  <= '0;
      tmout_err <= '0;
      undf_err  <= '0;
      for (int c = 0; c < DDR_NUM; c++) begin
        hold_addr[c] <= '0;
        hold_len[c]  <= '0;
        hold_id[c]   <= '0;
        cnt_q[c]     <= '0;
        us_cnt[c]    <= '0;
      end
    end else begin
      active_q <= 1'b1;
      tick_cnt <= tick ? 8'd0 : tick_cnt + 8'd1;
      if (accept && cfg_mode) begin
        rr_ptr <= (int'(tgt) == DDR_NUM - 1) ? '0 : tgt + 1'b1;
      end
      for (int c = 0; c < DDR_NUM; c++) begin
        if (ar_hs[c]) begin
          hold_vld[c] <= 1'b0;
        end
        if (accept && (tgt == SEL_W'(c))) begin
          hold_vld[c]  <= 1'b1;
          hold_addr[c] <= cmd_addr;
          hold_len[c]  <= cmd_len;
          hold_id[c]   <= cmd_id;
        end
        if (ar_hs[c] && !rlast_done[c]) begin
          cnt_q[c] <= cnt_q[c] + 4'd1;
        end else if (!ar_hs[c] && rlast_done[c] && (cnt_q[c] != 4'd0)) begin
          cnt_q[c] <= cnt_q[c] - 4'd1;
        end
        // The us counter saturates rather than wrapping so a stuck channel cannot re-arm silently.
        if (rlast_done[c] || (cnt_q[c] == 4'd0)) begin
          us_cnt[c] <= '0;
        end else if (tick && (us_cnt[c] != 16'hFFFF)) begin
          us_cnt[c] <= us_cnt[c] + 16'd1;
        end
        if ((reg_tmout_us_cfg != 16'd0) && (us_cnt[c] == reg_tmout_us_cfg)) begin
          tmout_err[c] <= 1'b1;
        end else if (cnt_reg_clr) begin
          tmout_err[c] <= 1'b0;
        end
        if (rlast_done[c] && !ar_hs[c] && (cnt_q[c] == 4'd0)) begin
          undf_err[c] <= 1'b1;
        end else if (cnt_reg_clr) begin
          undf_err[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmu_rx_rcmd_dispatch.sv
// Bench for mmu_rx_rcmd_dispatch: a cycle-level channel model is compared on every falling edge,
// alongside directed scenarios with hand-computed expectations.
module tb_mmu_rx_rcmd_dispatch;
  localparam int N = 4;

  logic         clk_sys = 1'b0;
  logic         rst_n = 1'b1;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic [3:0]   cmd_id;
  logic [15:0]  arid;
  logic [255:0] araddr;
  logic [31:0]  arlen;
  logic [11:0]  arsize;
  logic [3:0]   arvalid;
  logic [3:0]   arready;
  logic [3:0]   rlast_done;
  logic         cfg_en;
  logic         cfg_mode;
  logic [7:0]   reg_timer_1us_cfg;
  logic [15:0]  reg_tmout_us_cfg;
  logic         cnt_reg_clr;
  logic [15:0]  outs_cnt;
  logic [3:0]   tmout_err;
  logic [3:0]   undf_err;

  int vectors = 0;
  int miscompares = 0;

  bit          m_act;
  int          m_rr;
  int          m_tick;
  bit          m_hv   [N];
  logic [63:0] m_addr [N];
  logic [7:0]  m_len  [N];
  logic [3:0]  m_id   [N];
  int          m_outs [N];
  int          m_us   [N];
  bit          m_tmo  [N];
  bit          m_undf [N];

  mmu_rx_rcmd_dispatch dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .axi4m_ddr_arid(arid), .axi4m_ddr_araddr(araddr), .axi4m_ddr_arlen(arlen), .axi4m_ddr_arsize(arsize),
    .axi4m_ddr_arvalid(arvalid), .axi4m_ddr_arready(arready), .rlast_done(rlast_done),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .reg_timer_1us_cfg(reg_timer_1us_cfg),
    .reg_tmout_us_cfg(reg_tmout_us_cfg), .cnt_reg_clr(cnt_reg_clr),
    .outs_cnt(outs_cnt), .tmout_err(tmout_err), .undf_err(undf_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [63:0] a, input logic [7:0] l, input logic [3:0] id,
                               input logic [3:0] ardy, input logic [3:0] rl);
    @(negedge clk_sys);
    #1;
    cmd_valid  = v;
    cmd_addr   = a;
    cmd_len    = l;
    cmd_id     = id;
    arready    = ardy;
    rlast_done = rl;
  endtask

  // Chosen channel for the command currently on the inputs, or -1 when nothing can take it.
  function automatic int m_target();
    int c;
    if (cfg_mode) begin
      for (int i = 0; i < N; i++) begin
        c = (m_rr + i) % N;
        if (!m_hv[c] && m_outs[c] < 8) return c;
      end
      return -1;
    end
    c = int'(cmd_addr[35:34]);
    if (!m_hv[c] && m_outs[c] < 8) return c;
    return -1;
  endfunction

  function automatic bit m_ready();
    return m_act && cfg_en && (m_target() >= 0);
  endfunction

  task automatic modelReset();
    m_act = 0;
    m_rr = 0;
    m_tick = 0;
    for (int c = 0; c < N; c++) begin
      m_hv[c] = 0; m_addr[c] = '0; m_len[c] = '0; m_id[c] = '0;
      m_outs[c] = 0; m_us[c] = 0; m_tmo[c] = 0; m_undf[c] = 0;
    end
  endtask

  task automatic modelStep();
    int t;
    bit acc, tk, hs, uset;
    t  = m_target();
    acc = cmd_valid && m_ready();
    tk = (m_tick == int'(reg_timer_1us_cfg));
    m_tick = tk ? 0 : m_tick + 1;
    for (int c = 0; c < N; c++) begin
      hs = m_hv[c] && arready[c];
      if (reg_tmout_us_cfg != 0 && m_us[c] == int'(reg_tmout_us_cfg)) m_tmo[c] = 1;
      else if (cnt_reg_clr) m_tmo[c] = 0;
      if (rlast_done[c] || m_outs[c] == 0) m_us[c] = 0;
      else if (tk && m_us[c] < 65535) m_us[c] = m_us[c] + 1;
      uset = rlast_done[c] && !hs && m_outs[c] == 0;
      if (uset) m_undf[c] = 1;
      else if (cnt_reg_clr) m_undf[c] = 0;
      if (hs && !rlast_done[c]) m_outs[c] = m_outs[c] + 1;
      else if (!hs && rlast_done[c] && m_outs[c] > 0) m_outs[c] = m_outs[c] - 1;
      if (hs) m_hv[c] = 0;
      if (acc && t == c) begin
        m_hv[c] = 1; m_addr[c] = cmd_addr; m_len[c] = cmd_len; m_id[c] = cmd_id;
      end
    end
    if (acc && cfg_mode) m_rr = (t + 1) % N;
    m_act = 1;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk_sys or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  task automatic compareAll();
    logic [3:0]  ev, et, eu;
    logic [15:0] eo;
    logic [11:0] es;
    for (int c = 0; c < N; c++) begin
      ev[c] = m_hv[c];
      et[c] = m_tmo[c];
      eu[c] = m_undf[c];
      eo[c*4 +: 4] = 4'(m_outs[c]);
      es[c*3 +: 3] = m_act ? 3'b110 : 3'b000;
    end
    checkOutput("cmd_ready", 64'(cmd_ready), 64'(m_ready()));
    checkOutput("arvalid", 64'(arvalid), 64'(ev));
    checkOutput("outs_cnt", 64'(outs_cnt), 64'(eo));
    checkOutput("tmout_err", 64'(tmout_err), 64'(et));
    checkOutput("undf_err", 64'(undf_err), 64'(eu));
    checkOutput("arsize", 64'(arsize), 64'(es));
    for (int c = 0; c < N; c++) begin
      if (m_hv[c]) begin
        checkOutput($sformatf("araddr[%0d]", c), araddr[c*64 +: 64], m_addr[c]);
        checkOutput($sformatf("arlen[%0d]", c), 64'(arlen[c*8 +: 8]), 64'(m_len[c]));
        checkOutput($sformatf("arid[%0d]", c), 64'(arid[c*4 +: 4]), 64'(m_id[c]));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      compareAll();
    end
  end

  initial begin
    logic [3:0]  exp_order [10];
    logic [63:0] a0, a1, a2, a3;
    int          waited;
    a0 = 64'h0000_0000_0000_2000;
    a1 = 64'h0000_0004_0000_0040;
    a2 = 64'h0000_0008_0000_1000;
    a3 = 64'h0000_000C_0000_0080;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                  4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0110};
    cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    arready = 4'hF; rlast_done = '0;
    cfg_en = 1; cfg_mode = 0; reg_timer_1us_cfg = 8'd9; reg_tmout_us_cfg = 16'd0; cnt_reg_clr = 0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'h0);
    checkOutput("reset arvalid", 64'(arvalid), 64'h0);
    checkOutput("reset outs_cnt", 64'(outs_cnt), 64'h0);
    checkOutput("reset arsize", 64'(arsize), 64'h0);
    #10 rst_n = 1'b1;

    // Hash mode: address bits [35:34]=2 land on channel 2 one cycle after accept.
    applyStimulus(1, a2, 8'd7, 4'd5, 4'hF, 4'h0);
    @(posedge clk_sys); #1;
    checkOutput("t1 arvalid", 64'(arvalid), 64'h4);
    checkOutput("t1 araddr2", araddr[191:128], a2);
    checkOutput("t1 arlen2", 64'(arlen[23:16]), 64'h7);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'h0);
    @(posedge clk_sys); #1;
    checkOutput("t1 outs after hs", 64'(outs_cnt), 64'h0100);
    checkOutput("t1 arvalid drop", 64'(arvalid), 64'h0);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'b0100);
    @(posedge clk_sys); #1;
    checkOutput("t1 outs after rlast", 64'(outs_cnt), 64'h0);

    // Round-robin, then with channel 1 stalled.
    cfg_mode = 1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 64'(i) << 6, 8'(i), 4'(i), (i < 5) ? 4'hF : 4'b1101, 4'h0);
      @(posedge clk_sys); #1;
      checkOutput($sformatf("t2 order %0d", i), 64'(arvalid), 64'(exp_order[i]));
    end
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'h0);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'hF);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'hF);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'b0101);
    @(posedge clk_sys); #1;
    checkOutput("t2 drained", 64'(outs_cnt), 64'h0);
    cfg_mode = 0;

    // Credit cap on channel 0.
    for (int i = 0; i < 20; i++) applyStimulus(1, a0, 8'd3, 4'd1, 4'hF, 4'h0);
    @(posedge clk_sys); #1;
    checkOutput("t3 outs at cap", 64'(outs_cnt[3:0]), 64'h8);
    checkOutput("t3 ready at cap", 64'(cmd_ready), 64'h0);
    applyStimulus(1, a0, 8'd3, 4'd1, 4'hF, 4'b0001);
    @(posedge clk_sys); #1;
    checkOutput("t3 ready after rlast", 64'(cmd_ready), 64'h1);
    checkOutput("t3 outs after rlast", 64'(outs_cnt[3:0]), 64'h7);
    for (int i = 0; i < 7; i++) applyStimulus(0, a0, 8'd0, 4'd0, 4'hF, 4'b0001);
    @(posedge clk_sys); #1;
    checkOutput("t3 drained", 64'(outs_cnt), 64'h0);

    // Simultaneous handshake and rlast on channel 3, then underflow.
    for (int i = 0; i < 10; i++) applyStimulus(1, a3, 8'd1, 4'd3, 4'hF, 4'h0);
    @(posedge clk_sys); #1;
    checkOutput("t4 outs 5", 64'(outs_cnt[15:12]), 64'h5);
    applyStimulus(1, a3, 8'd1, 4'd3, 4'hF, 4'h0);
    @(posedge clk_sys); #1;
    checkOutput("t4 held", 64'(arvalid), 64'h8);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'b1000);
    @(posedge clk_sys); #1;
    checkOutput("t4 hs+rlast", 64'(outs_cnt[15:12]), 64'h5);
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'b1000);
    @(posedge clk_sys); #1;
    checkOutput("t4 drained", 64'(outs_cnt), 64'h0);
    checkOutput("t4 no undf yet", 64'(undf_err), 64'h0);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'b1000);
    @(posedge clk_sys); #1;
    checkOutput("t4 undf set", 64'(undf_err), 64'h8);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'h0);
    cnt_reg_clr = 1;
    @(posedge clk_sys); #1;
    checkOutput("t4 undf cleared", 64'(undf_err), 64'h0);
    cnt_reg_clr = 0;

    // Timeout on channel 1: 10-cycle us tick, 3 us limit.
    reg_tmout_us_cfg = 16'd3;
    applyStimulus(1, a1, 8'd0, 4'd2, 4'hF, 4'h0);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'h0);
    waited = 0;
    while (tmout_err[1] !== 1'b1 && waited < 60) begin
      @(posedge clk_sys); #1;
      waited++;
    end
    checkOutput("t5 tmout set", 64'(tmout_err), 64'h2);
    checkOutput("t5 tmout latency", 64'(waited >= 20 && waited <= 40), 64'h1);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'b0010);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'h0);
    cnt_reg_clr = 1;
    @(posedge clk_sys); #1;
    checkOutput("t5 tmout cleared", 64'(tmout_err), 64'h0);
    cnt_reg_clr = 0;
    reg_tmout_us_cfg = 16'd0;
    applyStimulus(1, a1, 8'd0, 4'd2, 4'hF, 4'h0);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'h0);
    repeat (60) @(posedge clk_sys);
    #1;
    checkOutput("t5 disabled", 64'(tmout_err), 64'h0);
    applyStimulus(0, '0, 8'd0, 4'd0, 4'hF, 4'b0010);
    @(posedge clk_sys); #1;
    checkOutput("t5 drained", 64'(outs_cnt), 64'h0);

    // Asynchronous reset with a held AR and four bursts outstanding.
    for (int i = 0; i < 8; i++) applyStimulus(1, a0, 8'd2, 4'd6, 4'hF, 4'h0);
    applyStimulus(1, a0, 8'd2, 4'd6, 4'hE, 4'h0);
    @(posedge clk_sys); #1;
    checkOutput("t6 held", 64'(arvalid), 64'h1);
    checkOutput("t6 outs 4", 64'(outs_cnt[3:0]), 64'h4);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6 rst arvalid", 64'(arvalid), 64'h0);
    checkOutput("t6 rst outs", 64'(outs_cnt), 64'h0);
    checkOutput("t6 rst ready", 64'(cmd_ready), 64'h0);
    checkOutput("t6 rst araddr0", araddr[63:0], 64'h0);
    checkOutput("t6 rst arsize", 64'(arsize), 64'h0);
    cmd_valid = 0;
    arready = 4'hF;
    repeat (2) @(negedge clk_sys);
    #2 rst_n = 1'b1;
    @(posedge clk_sys); #1;
    checkOutput("t6 ready back", 64'(cmd_ready), 64'h1);
    checkOutput("t6 no reissue", 64'(arvalid), 64'h0);
    repeat (3) @(posedge clk_sys);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
